// File: rtl/io_led_switch_ctrl_pkg.sv
// Shared address map, widths and read-decode helper for the LED/switch I/O peripheral.
// Latency: n/a (constants and pure functions only); backpressure: n/a.
package io_led_switch_ctrl_pkg;

  localparam int IO_W = 24;

  localparam logic [7:0] LED_BASE   = 8'h60;
  localparam logic [7:0] LED_HI     = LED_BASE + 8'h02;
  localparam logic [7:0] SW_BASE    = 8'h70;
  localparam logic [7:0] SW_HI      = SW_BASE + 8'h02;
  localparam logic [7:0] STATUS_OFF = 8'h04;
  localparam logic [7:0] SW_STATUS  = SW_BASE + STATUS_OFF;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_SW_LO,
    RD_SW_HI,
    RD_STATUS
  } rd_sel_e;

  function automatic rd_sel_e decode_read(input logic cs, input logic [7:0] offset);
    rd_sel_e sel;
    sel = RD_NONE;
    if (cs) begin
      case (offset)
        SW_BASE:   sel = RD_SW_LO;
        SW_HI:     sel = RD_SW_HI;
        SW_STATUS: sel = RD_STATUS;
        default:   sel = RD_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_led_switch_ctrl_if.sv
// CPU-side I/O bus between the memory/IO mux stage and the LED/switch peripheral.
// Latency: read data is combinational; backpressure: none, every access completes in one cycle.
interface io_led_switch_ctrl_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        led_cs;
  logic        switch_cs;
  logic [15:0] ioread_data;

  modport master (
    output address, write_data, led_cs, switch_cs,
    input  ioread_data
  );

  modport slave (
    input  address, write_data, led_cs, switch_cs,
    output ioread_data
  );
endinterface

// File: rtl/io_led_switch_ctrl_sw_debounce.sv
// Switch synchroniser + whole-vector debouncer with sticky change flag.
// Latency: 2 sync + 1 candidate load + DEBOUNCE_CYCLES edges; backpressure: none.
module io_led_switch_ctrl_sw_debounce
  import io_led_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IO_W-1:0] switch_in,
  input  logic            clear,
  output logic [IO_W-1:0] stable,
  output logic            changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IO_W-1:0]  sync1;
  logic [IO_W-1:0]  sync2;
  logic [IO_W-1:0]  candidate;
  logic [CNT_W-1:0] counter;
  logic             commit;

  assign commit = (sync2 == candidate) && (counter == CNT_MAX) && (candidate != stable);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      counter   <= '0;
      stable    <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate <= sync2;
        counter   <= '0;
      end else if (commit) begin
        stable <= candidate;
      end else if (counter < CNT_MAX) begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

  // A commit on the same edge as a status read must not be lost, so set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      changed <= 1'b0;
    end else if (commit) begin
      changed <= 1'b1;
    end else if (clear) begin
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/io_led_switch_ctrl.sv
// Memory-mapped LED/switch peripheral: registered LED outputs, debounced switch readback.
// Latency: LED write visible 1 cycle after the edge, reads combinational; backpressure: none.
module io_led_switch_ctrl
  import io_led_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic             clock,
  input  logic             reset,
  io_led_switch_ctrl_if.slave bus,
  input  logic [IO_W-1:0]  switch_in,
  output logic [IO_W-1:0]  led_out
);

  logic [7:0]      offset;
  logic [IO_W-1:0] stable;
  logic            changed;
  logic            status_clr;
  rd_sel_e         rd_sel;
  logic            unused_bus_bits;

  assign offset          = bus.address[7:0];
  assign unused_bus_bits = ^{bus.address[31:8], bus.write_data[31:16]};
  assign status_clr      = bus.switch_cs && (offset == SW_STATUS);
  assign rd_sel          = decode_read(bus.switch_cs, offset);

  io_led_switch_ctrl_sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_debounce (
    .clock     (clock),
    .reset     (reset),
    .switch_in (switch_in),
    .clear     (status_clr),
    .stable    (stable),
    .changed   (changed)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
    end else if (bus.led_cs) begin
      if (offset == LED_BASE) begin
        led_out[15:0] <= bus.write_data[15:0];
      end else if (offset == LED_HI) begin
        led_out[23:16] <= bus.write_data[7:0];
      end
    end
  end

  always_comb begin
    bus.ioread_data = 16'h0000;
    case (rd_sel)
      RD_SW_LO:  bus.ioread_data = stable[15:0];
      RD_SW_HI:  bus.ioread_data = {8'h00, stable[23:16]};
      RD_STATUS: bus.ioread_data = {15'b0, changed};
      default:   bus.ioread_data = 16'h0000;
    endcase
  end

endmodule
